// File: rtl/approx_prod_accum.sv
// Streaming dot-product accumulator for 16-bit approximate products.
// One input register stage feeding a two-state accumulate/hold FSM.
module approx_prod_accum #(
   parameter int VEC_LEN = 16,
   parameter int ACC_W   = 24,
   parameter int SAT     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      in_prod,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [7:0]       out_count,
   output logic             out_ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic {ACC, HOLD} state_t;

   localparam logic [7:0] CNT_END = 8'(VEC_LEN - 1);

   state_t           state;
   logic [15:0]      p_reg;
   logic             p_last;
   logic             p_vld;
   logic [ACC_W-1:0] acc;
   logic [7:0]       cnt;
   logic             sticky;

   logic             load;
   logic             take;
   logic [ACC_W-1:0] base;
   logic [ACC_W:0]   nxt;
   logic             n_ovf;
   logic [ACC_W-1:0] res;
   logic             v_end;

   assign in_ready = !p_vld || (state == ACC);
   assign load     = in_valid && in_ready;
   assign take     = p_vld && (state == ACC);

   // The first product of a vector ignores whatever acc still holds.
   always_comb begin
      base  = (cnt == 8'd0) ? '0 : acc;
      nxt   = {1'b0, base} + (ACC_W+1)'(p_reg);
      n_ovf = nxt[ACC_W];
      res   = (n_ovf && SAT != 0) ? '1 : nxt[ACC_W-1:0];
      v_end = p_last || (cnt == CNT_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         p_reg     <= '0;
         p_last    <= 1'b0;
         p_vld     <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         sticky    <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (load) begin
            p_reg  <= in_prod;
            p_last <= in_last;
            p_vld  <= 1'b1;
         end else if (take) begin
            p_vld  <= 1'b0;
         end

         case (state)
            ACC: begin
               if (p_vld) begin
                  acc    <= res;
                  cnt    <= cnt + 8'd1;
                  sticky <= sticky | n_ovf;
                  if (v_end) begin
                     out_sum   <= res;
                     out_count <= cnt + 8'd1;
                     out_ovf   <= sticky | n_ovf;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  sticky    <= 1'b0;
                  state     <= ACC;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed and randomized checks of approx_prod_accum in three configurations.
// Shared stimulus drives 24-bit saturating, 16-bit saturating and 16-bit wrapping instances.
module tb_approx_prod_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_prod = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        rdy0, rdy1, rdy2;
   logic [23:0] sum0;
   logic [15:0] sum1, sum2;
   logic [7:0]  cnt0, cnt1, cnt2;
   logic        ovf0, ovf1, ovf2;
   logic        vld0, vld1, vld2;

   always #5 clk = ~clk;

   approx_prod_accum #(.VEC_LEN(16), .ACC_W(24), .SAT(1)) u0 (
      .clk(clk), .rst(rst), .in_prod(in_prod), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy0), .out_sum(sum0),
      .out_count(cnt0), .out_ovf(ovf0), .out_valid(vld0),
      .out_ready(out_ready));

   approx_prod_accum #(.VEC_LEN(16), .ACC_W(16), .SAT(1)) u1 (
      .clk(clk), .rst(rst), .in_prod(in_prod), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy1), .out_sum(sum1),
      .out_count(cnt1), .out_ovf(ovf1), .out_valid(vld1),
      .out_ready(out_ready));

   approx_prod_accum #(.VEC_LEN(16), .ACC_W(16), .SAT(0)) u2 (
      .clk(clk), .rst(rst), .in_prod(in_prod), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy2), .out_sum(sum2),
      .out_count(cnt2), .out_ovf(ovf2), .out_valid(vld2),
      .out_ready(out_ready));

   typedef struct {
      longint s0, s1, s2;
      bit     o0, o1, o2;
      int     c;
   } res_t;

   int     total = 0;
   int     bad = 0;
   int     ncyc = 0;
   int     t_acc = 0;
   int     t_vld = 0;
   bit     seen_v = 0;
   bit     hold_prev = 0;
   bit     acc_now = 0;
   bit     rnd_rdy = 0;
   res_t   q[$];

   longint m_acc[3];
   bit     m_sk[3];
   int     m_cnt = 0;
   int     cw[3] = '{24, 16, 16};
   bit     cs[3] = '{1'b1, 1'b1, 1'b0};

   logic [23:0] ps0;
   logic [15:0] ps1, ps2;
   logic [7:0]  pc;
   logic        po;
   longint      r_s0, r_s1, r_s2;
   bit          r_o0, r_o1, r_o2;
   int          r_c;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic madd(input longint p, input bit l);
      longint n;
      res_t   e;
      for (int i = 0; i < 3; i++) begin
         if (m_cnt == 0) begin
            m_acc[i] = 0;
            m_sk[i]  = 0;
         end
         n = m_acc[i] + p;
         if (n >= (64'd1 << cw[i])) begin
            m_sk[i] = 1;
            n = cs[i] ? (64'd1 << cw[i]) - 1 : n - (64'd1 << cw[i]);
         end
         m_acc[i] = n;
      end
      m_cnt++;
      if (l || m_cnt == 16) begin
         e.s0 = m_acc[0]; e.s1 = m_acc[1]; e.s2 = m_acc[2];
         e.o0 = m_sk[0];  e.o1 = m_sk[1];  e.o2 = m_sk[2];
         e.c  = m_cnt;
         q.push_back(e);
         m_cnt = 0;
         t_acc = ncyc;
      end
   endtask

   task automatic cyc(input bit v, input logic [15:0] p, input bit l, input bit r);
      bit   hs;
      res_t e;
      @(negedge clk);
      in_valid  = v;
      in_prod   = p;
      in_last   = l;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : r;
      #1;
      ncyc++;
      chk("ctl_match", {vld1, vld2, rdy1, rdy2}, {vld0, vld0, rdy0, rdy0});
      if (hold_prev) begin
         chk("stable", {sum0, sum1, sum2, cnt0, ovf0}, {ps0, ps1, ps2, pc, po});
      end
      if (vld0 && !seen_v) t_vld = ncyc;
      seen_v  = vld0;
      hs      = vld0 && out_ready;
      acc_now = v && rdy0;
      if (hs) begin
         if (q.size() == 0) begin
            chk("spurious_result", 1, 0);
         end else begin
            e = q.pop_front();
            chk("sum24", sum0, e.s0);
            chk("sum16s", sum1, e.s1);
            chk("sum16w", sum2, e.s2);
            chk("ovf", {ovf0, ovf1, ovf2}, {e.o0, e.o1, e.o2});
            chk("count", {cnt0, cnt1, cnt2}, {8'(e.c), 8'(e.c), 8'(e.c)});
         end
         r_s0 = sum0; r_s1 = sum1; r_s2 = sum2;
         r_o0 = ovf0; r_o1 = ovf1; r_o2 = ovf2;
         r_c  = cnt0;
      end
      if (acc_now) madd(longint'(p), l);
      hold_prev = vld0 && !hs;
      ps0 = sum0; ps1 = sum1; ps2 = sum2; pc = cnt0; po = ovf0;
   endtask

   task automatic send(input logic [15:0] p, input bit l, input bit r);
      for (int k = 0; k < 200; k++) begin
         cyc(1'b1, p, l, r);
         if (acc_now) return;
      end
      chk("send_timeout", 1, 0);
   endtask

   task automatic drain();
      rnd_rdy = 0;
      for (int k = 0; k < 100; k++) begin
         if (q.size() == 0 && !vld0) return;
         cyc(1'b0, 16'h0, 1'b0, 1'b1);
      end
      chk("drain_timeout", 1, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_vld", vld0, 0);
      chk("rst_rdy", rdy0, 1);
      chk("rst_outs", {sum0, cnt0, ovf0}, 0);
      rst = 1'b0;
      q.delete();
      m_cnt     = 0;
      hold_prev = 0;
      seen_v    = 0;
   endtask

   initial begin
      do_reset();

      for (int i = 0; i < 16; i++) send(16'h0100, 1'b0, 1'b1);
      drain();
      chk("t1_sum", r_s0, 64'h1000);
      chk("t1_cnt", r_c, 16);
      chk("t1_ovf", r_o0, 0);
      chk("t1_latency", t_vld - t_acc, 2);

      send(16'd5, 1'b0, 1'b1);
      send(16'd7, 1'b0, 1'b1);
      send(16'd9, 1'b1, 1'b1);
      drain();
      chk("t2_sum", r_s0, 21);
      chk("t2_cnt", r_c, 3);
      send(16'd4, 1'b1, 1'b1);
      drain();
      chk("t2_first_last_sum", r_s0, 4);
      chk("t2_first_last_cnt", r_c, 1);

      send(16'hFFFF, 1'b0, 1'b1);
      send(16'h0002, 1'b1, 1'b1);
      drain();
      chk("t3_sat_sum", r_s1, 64'hFFFF);
      chk("t3_sat_ovf", r_o1, 1);
      chk("t3_wrap_sum", r_s2, 1);
      chk("t3_wrap_ovf", r_o2, 1);
      chk("t3_wide_sum", r_s0, 64'h10001);
      chk("t3_wide_ovf", r_o0, 0);

      send(16'd1, 1'b0, 1'b0);
      send(16'd2, 1'b0, 1'b0);
      send(16'd3, 1'b1, 1'b0);
      cyc(1'b1, 16'd10, 1'b0, 1'b0);
      chk("t4_acc10", acc_now, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 16'd11, 1'b0, 1'b0);
         chk("t4_stall_rdy", rdy0, 0);
         chk("t4_vld", vld0, 1);
         chk("t4_held_sum", sum0, 6);
      end
      send(16'd11, 1'b0, 1'b1);
      send(16'd12, 1'b1, 1'b1);
      drain();
      chk("t4_next_sum", r_s0, 33);
      chk("t4_next_cnt", r_c, 3);

      for (int i = 0; i < 7; i++) send(16'h0100, 1'b0, 1'b1);
      do_reset();
      send(16'd1, 1'b0, 1'b1);
      send(16'd2, 1'b0, 1'b1);
      send(16'd3, 1'b0, 1'b1);
      send(16'd4, 1'b1, 1'b1);
      drain();
      chk("t6_sum", r_s0, 10);
      chk("t6_cnt", r_c, 4);

      rnd_rdy = 1;
      for (int v = 0; v < 1000; v++) begin
         int len;
         bit lst;
         len = $urandom_range(1, 16);
         for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 2) == 0) cyc(1'b0, 16'h0, 1'b0, 1'b0);
            lst = (i == len - 1);
            if (len == 16 && $urandom_range(0, 1) == 0) lst = 0;
            send(16'($urandom), lst, 1'b0);
         end
      end
      drain();
      chk("t5_queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
